conv_kern_seq: RTL and testbench
================================

Name: conv_kern_seq

Overview:
Layer-level sequencer for the conv_kern MAC datapath. It walks all output channels, output pixels and input-channel chunks of one layer, and issues the read requests to the weight and activation buffers. It drives conv_kern's vld_i, counts returned results, writes them out through the output address counter, and throttles issue with a credit counter. It sits between the layer control registers and conv_kern plus its buffers.

Parameters:
N, 16, input channels per beat (lanes per MAC)
ADDR_BITS, 16, width of weight, activation and output buffer addresses
MAX_OUTSTANDING, 4, max issued-but-unreturned output pixels (1..15)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  start-of-layer pulse; ignored unless IDLE
in_ch  in  8  input channel count; 0 encodes 256
out_w  in  8  output width
out_h  in  8  output height
out_ch  in  8  output channels (filters)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at layer completion
w_rd_en  out  1  weight buffer read enable
w_rd_addr  out  ADDR_BITS  weight buffer address
d_rd_en  out  1  activation buffer read enable
d_rd_addr  out  ADDR_BITS  activation buffer address
kern_vld_i  out  1  to conv_kern vld_i; w_rd_en delayed 1 cycle
kern_first  out  1  beat is chunk 0 of a pixel; aligned with kern_vld_i
kern_last  out  1  beat is last chunk of a pixel; aligned with kern_vld_i
kern_vld_o  in  1  conv_kern vld_o, one pulse per finished pixel
o_wr_en  out  1  equals kern_vld_o when accepted
o_wr_addr  out  ADDR_BITS  output address, sequential from 0
err  out  1  sticky; kern_vld_o received with zero outstanding

Behaviour:
- Reset: all outputs 0; FSM=IDLE; all counters 0; err cleared only by rstn.
- Config latch: on start in IDLE, latch in_ch, out_w, out_h and out_ch. Also compute NC = ceil(in_ch_eff/N), with in_ch_eff = in_ch, or 256 when in_ch = 0. NC is 5 bits (1..16).
- FSM states IDLE -> CFG -> RUN -> DRAIN -> DONE -> IDLE.
- CFG: one cycle. Clear the counters. If out_w, out_h or out_ch is 0, go directly to DONE.
- Loop order: f (0..out_ch-1) outermost, then y, then x, then chunk c (0..NC-1) innermost.
- One beat per cycle in RUN: assert w_rd_en and d_rd_en together.
- d_rd_addr: increments every beat and returns to 0 when f advances. It equals pixel*NC + c.
- w_rd_addr = wbase + c. wbase starts at 0 and advances by NC when f advances. Both are built with counters only; no multipliers.
- Addresses wrap modulo 2^ADDR_BITS; no overflow flag.
- Credit throttle: beat c=0 is issued only if outstanding < MAX_OUTSTANDING. Otherwise rd_en is held low, with no bubbles inside a pixel.
- Outstanding counter: increments when the c=NC-1 beat issues and decrements on accepted kern_vld_o. If both happen in the same cycle, the count is unchanged.
- Beat alignment: kern_vld_i, kern_first and kern_last are the issue-cycle values registered once, matching 1-cycle buffer read latency. With NC = 1, kern_first and kern_last are both high.
- RUN -> DRAIN: in the cycle after issuing the final beat (f=out_ch-1, y=out_h-1, x=out_w-1, c=NC-1).
- DRAIN -> DONE: when outstanding is 0 and no kern_vld_i is in flight.
- DONE: done=1 for one cycle, busy drops in the same cycle, then return to IDLE.
- Outputs: o_wr_en = kern_vld_o & (outstanding != 0); o_wr_addr increments after each write.
- Spurious result: kern_vld_o with outstanding = 0 sets err and does not write.
- kern_vld_o is accepted in any state except IDLE. In IDLE it counts as spurious.
- start while busy is ignored; config inputs may change freely while busy.
- rstn low mid-layer: immediate return to reset values; no done pulse.

Test Plan:
- in_ch=3, out 2x2, out_ch=1, kernel returns each pixel 3 cycles after kern_last -> NC=1; 4 consecutive beats with w_rd_addr=0,0,0,0 and d_rd_addr=0,1,2,3; o_wr_addr 0..3; one done pulse; err=0.
- in_ch=40, out 1x2, out_ch=2 -> NC=3; w_rd_addr 0,1,2,0,1,2,3,4,5,3,4,5; d_rd_addr 0..5,0..5; kern_first on beats 0,3,6,9; kern_last on beats 2,5,8,11.
- MAX_OUTSTANDING=2, in_ch=16, out 4x1, kern_vld_o withheld -> exactly 2 beats issued, then rd_en stays low. One kern_vld_o pulse -> exactly one more beat issues. Returning all results -> done.
- in_ch=0 -> NC=16; out_w=0 -> done asserts 2 cycles after start with zero beats issued; start pulsed during busy in another run -> ignored.
- kern_vld_o pulsed in IDLE -> err=1, o_wr_en=0; err stays 1 across the next layer until rstn.
- rstn asserted mid-RUN -> busy, rd_en and kern_vld_i drop to 0 immediately; after release, a new start runs the full sequence from address 0.

Source files
------------

// File: rtl/conv_kern_seq.sv
// Layer sequencer for the conv_kern MAC datapath: walks filters, pixels and input-channel
// chunks, issues buffer reads with credit throttling, and writes returned pixel results out.
module conv_kern_seq #(
  parameter int N               = 16,
  parameter int ADDR_BITS       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [7:0]           in_ch,
  input  logic [7:0]           out_w,
  input  logic [7:0]           out_h,
  input  logic [7:0]           out_ch,
  output logic                 busy,
  output logic                 done,
  output logic                 w_rd_en,
  output logic [ADDR_BITS-1:0] w_rd_addr,
  output logic                 d_rd_en,
  output logic [ADDR_BITS-1:0] d_rd_addr,
  output logic                 kern_vld_i,
  output logic                 kern_first,
  output logic                 kern_last,
  input  logic                 kern_vld_o,
  output logic                 o_wr_en,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic                 err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [7:0]           out_w_r;
  logic [7:0]           out_h_r;
  logic [7:0]           out_ch_r;
  logic [4:0]           nc_r;
  logic [4:0]           c_r;
  logic [7:0]           x_r;
  logic [7:0]           y_r;
  logic [7:0]           f_r;
  logic [ADDR_BITS-1:0] d_ptr_r;
  logic [ADDR_BITS-1:0] wbase_r;
  logic [3:0]           outstanding_r;
  logic [ADDR_BITS-1:0] o_wr_addr_r;
  logic                 beat_first_r;
  logic                 beat_last_r;

  logic [9:0] in_ch_eff_s;
  logic [4:0] nc_calc_s;
  logic       c_last_s;
  logic       x_last_s;
  logic       y_last_s;
  logic       f_last_s;
  logic       final_s;
  logic       credit_ok_s;
  logic       issue_s;
  logic       accept_s;
  logic       zero_dim_s;

  // Beat position decode, credit gating and result acceptance
  always_comb begin
    in_ch_eff_s = (in_ch == 8'd0) ? 10'd256 : {2'b00, in_ch};
    nc_calc_s   = 5'((in_ch_eff_s + 10'(N - 1)) / 10'(N));
    c_last_s    = (c_r == (nc_r - 5'd1));
    x_last_s    = (x_r == (out_w_r - 8'd1));
    y_last_s    = (y_r == (out_h_r - 8'd1));
    f_last_s    = (f_r == (out_ch_r - 8'd1));
    final_s     = c_last_s && x_last_s && y_last_s && f_last_s;
    // Only the first chunk of a pixel waits for credit; later chunks never bubble
    credit_ok_s = (c_r != 5'd0) || (outstanding_r < 4'(MAX_OUTSTANDING));
    issue_s     = (state_r == ST_RUN) && credit_ok_s;
    accept_s    = kern_vld_o && (outstanding_r != 4'd0) && (state_r != ST_IDLE);
    zero_dim_s  = (out_w_r == 8'd0) || (out_h_r == 8'd0) || (out_ch_r == 8'd0);
  end

  assign o_wr_en   = accept_s;
  assign o_wr_addr = o_wr_addr_r;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_CFG;
        else       state_s = ST_IDLE;
      end
      ST_CFG: begin
        if (zero_dim_s) state_s = ST_DONE;
        else            state_s = ST_RUN;
      end
      ST_RUN: begin
        if (issue_s && final_s) state_s = ST_DRAIN;
        else                    state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if ((outstanding_r == 4'd0) && !w_rd_en && !kern_vld_i) state_s = ST_DONE;
        else                                                     state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered status outputs follow the next state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_s == ST_CFG) || (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done <= (state_s == ST_DONE);
    end
  end

  // Layer configuration latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_w_r  <= 8'd0;
      out_h_r  <= 8'd0;
      out_ch_r <= 8'd0;
      nc_r     <= 5'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      out_w_r  <= out_w;
      out_h_r  <= out_h;
      out_ch_r <= out_ch;
      nc_r     <= nc_calc_s;
    end
  end

  // Loop counters, address pointers, credit and output address counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_r           <= 5'd0;
      x_r           <= 8'd0;
      y_r           <= 8'd0;
      f_r           <= 8'd0;
      d_ptr_r       <= '0;
      wbase_r       <= '0;
      outstanding_r <= 4'd0;
      o_wr_addr_r   <= '0;
    end else if (state_r == ST_CFG) begin
      c_r           <= 5'd0;
      x_r           <= 8'd0;
      y_r           <= 8'd0;
      f_r           <= 8'd0;
      d_ptr_r       <= '0;
      wbase_r       <= '0;
      outstanding_r <= 4'd0;
      o_wr_addr_r   <= '0;
    end else begin
      if (issue_s) begin
        if (!c_last_s) begin
          c_r     <= c_r + 5'd1;
          d_ptr_r <= d_ptr_r + ADDR_BITS'(1'b1);
        end else begin
          c_r <= 5'd0;
          if (!x_last_s) begin
            x_r     <= x_r + 8'd1;
            d_ptr_r <= d_ptr_r + ADDR_BITS'(1'b1);
          end else begin
            x_r <= 8'd0;
            if (!y_last_s) begin
              y_r     <= y_r + 8'd1;
              d_ptr_r <= d_ptr_r + ADDR_BITS'(1'b1);
            end else begin
              // Next filter: activations restart, weights move to the next filter block
              y_r     <= 8'd0;
              d_ptr_r <= '0;
              wbase_r <= wbase_r + ADDR_BITS'(nc_r);
              f_r     <= f_last_s ? 8'd0 : (f_r + 8'd1);
            end
          end
        end
      end
      case ({issue_s && c_last_s, accept_s})
        2'b10:   outstanding_r <= outstanding_r + 4'd1;
        2'b01:   outstanding_r <= outstanding_r - 4'd1;
        default: outstanding_r <= outstanding_r;
      endcase
      if (accept_s) begin
        o_wr_addr_r <= o_wr_addr_r + ADDR_BITS'(1'b1);
      end
    end
  end

  // Read request outputs and their one-cycle-delayed kernel qualifiers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_rd_en      <= 1'b0;
      d_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      d_rd_addr    <= '0;
      beat_first_r <= 1'b0;
      beat_last_r  <= 1'b0;
      kern_vld_i   <= 1'b0;
      kern_first   <= 1'b0;
      kern_last    <= 1'b0;
    end else begin
      w_rd_en      <= issue_s;
      d_rd_en      <= issue_s;
      beat_first_r <= issue_s && (c_r == 5'd0);
      beat_last_r  <= issue_s && c_last_s;
      if (issue_s) begin
        w_rd_addr <= wbase_r + ADDR_BITS'(c_r);
        d_rd_addr <= d_ptr_r;
      end
      kern_vld_i <= w_rd_en;
      kern_first <= beat_first_r;
      kern_last  <= beat_last_r;
    end
  end

  // Sticky flag for results arriving with nothing outstanding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (kern_vld_o && !accept_s) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_kern_seq.sv
// Randomized self-checking bench for conv_kern_seq with a loop-level reference model
// and an in-order kernel responder.
module tb_conv_kern_seq;
  localparam int N    = 16;
  localparam int AB   = 16;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_ch = 8'd0, out_w = 8'd0, out_h = 8'd0, out_ch = 8'd0;
  logic          kern_vld_o = 1'b0;
  logic          busy, done, w_rd_en, d_rd_en, kern_vld_i, kern_first, kern_last;
  logic          o_wr_en, err;
  logic [AB-1:0] w_rd_addr, d_rd_addr, o_wr_addr;

  conv_kern_seq #(.N(N), .ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_ch(in_ch), .out_w(out_w), .out_h(out_h), .out_ch(out_ch),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .d_rd_en(d_rd_en), .d_rd_addr(d_rd_addr),
    .kern_vld_i(kern_vld_i), .kern_first(kern_first), .kern_last(kern_last),
    .kern_vld_o(kern_vld_o), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int d;
    bit f;
    bit l;
  } beat_t;

  beat_t exp_q[$];
  int    due_q[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, beats = 0, n_exp = 0, done_cnt = 0;
  int    model_out = 0, reg_out = 0, model_wr = 0, delay = 3;
  int    manual = 0, spur = 0, t = 0;
  bit    model_err = 1'b0, prev_rd = 1'b0, prev_f = 1'b0, prev_l = 1'b0, hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: check registered outputs, drive the kernel response, check the write port
  task automatic tick();
    beat_t b;
    @(posedge clk);
    #1;
    cyc++;
    chk("err", err, model_err);
    chk("kern_vld_i", kern_vld_i, prev_rd);
    if (kern_vld_i) begin
      chk("kern_first", kern_first, prev_f);
      chk("kern_last", kern_last, prev_l);
      if (prev_l) due_q.push_back(cyc + delay);
    end
    chk("d_rd_en", d_rd_en, w_rd_en);
    prev_rd = w_rd_en;
    prev_f  = 1'b0;
    prev_l  = 1'b0;
    if (w_rd_en) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("beat_count", beats, n_exp);
      end else begin
        b = exp_q.pop_front();
        chk("w_rd_addr", w_rd_addr, b.w);
        chk("d_rd_addr", d_rd_addr, b.d);
        prev_f = b.f;
        prev_l = b.l;
        if (b.f) chk("credit_at_issue", reg_out < MAXO, 1);
        if (b.l) model_out++;
      end
    end
    reg_out = model_out;
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    kern_vld_o = 1'b0;
    if (spur > 0) begin
      kern_vld_o = 1'b1;
      spur--;
    end else if (due_q.size() > 0 && ((!hold && due_q[0] <= cyc) || (hold && manual > 0))) begin
      kern_vld_o = 1'b1;
      void'(due_q.pop_front());
      if (hold) manual--;
    end
    #1;
    if (kern_vld_o && model_out > 0) begin
      chk("o_wr_en", o_wr_en, 1);
      chk("o_wr_addr", o_wr_addr, model_wr);
      model_out--;
      model_wr++;
    end else begin
      chk("o_wr_en", o_wr_en, 0);
      if (kern_vld_o) model_err = 1'b1;
    end
  endtask

  task automatic reset_checks();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_rd_en", w_rd_en, 0);
    chk("rst_d_rd_en", d_rd_en, 0);
    chk("rst_w_rd_addr", w_rd_addr, 0);
    chk("rst_d_rd_addr", d_rd_addr, 0);
    chk("rst_kern_vld_i", kern_vld_i, 0);
    chk("rst_kern_first", kern_first, 0);
    chk("rst_kern_last", kern_last, 0);
    chk("rst_o_wr_en", o_wr_en, 0);
    chk("rst_o_wr_addr", o_wr_addr, 0);
    chk("rst_err", err, 0);
  endtask

  // Reference beat list: filter outermost, then pixel (row-major), then chunk
  task automatic start_layer(input int ic, input int w, input int h, input int oc);
    beat_t b;
    int nc;
    nc = (((ic == 0) ? 256 : ic) + N - 1) / N;
    exp_q.delete();
    if (w > 0 && h > 0 && oc > 0) begin
      for (int f = 0; f < oc; f++)
        for (int p = 0; p < w * h; p++)
          for (int c = 0; c < nc; c++) begin
            b.w = (f * nc + c) % 65536;
            b.d = (p * nc + c) % 65536;
            b.f = (c == 0);
            b.l = (c == nc - 1);
            exp_q.push_back(b);
          end
    end
    n_exp    = exp_q.size();
    beats    = 0;
    model_wr = 0;
    done_cnt = 0;
    in_ch  = 8'(ic);
    out_w  = 8'(w);
    out_h  = 8'(h);
    out_ch = 8'(oc);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, input int poke_at, output int ticks);
    ticks = 1;
    while (done_cnt == 0 && ticks < budget) begin
      if (ticks == poke_at) begin
        start  = 1'b1;
        in_ch  = 8'($urandom);
        out_w  = 8'($urandom);
        out_h  = 8'($urandom);
        out_ch = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      ticks++;
    end
    start = 1'b0;
    chk("done_seen", done_cnt, 1);
    chk("beat_count", beats, n_exp);
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic mid_reset();
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_w_rd_en", w_rd_en, 0);
    chk("arst_d_rd_en", d_rd_en, 0);
    chk("arst_kern_vld_i", kern_vld_i, 0);
    exp_q.delete();
    due_q.delete();
    model_out = 0; reg_out = 0; model_err = 1'b0;
    prev_rd = 1'b0; prev_f = 1'b0; prev_l = 1'b0;
    spur = 0; manual = 0; kern_vld_o = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    reset_checks();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rstn = 1'b1;

    delay = 3;
    start_layer(3, 2, 2, 1);
    wait_done(2000, -1, t);

    start_layer(40, 2, 1, 2);
    wait_done(2000, -1, t);

    hold = 1'b1;
    start_layer(16, 4, 1, 1);
    repeat (10) tick();
    chk("throttle_first", beats, 2);
    manual = 1;
    repeat (10) tick();
    chk("throttle_after_one", beats, 3);
    hold = 1'b0;
    wait_done(2000, -1, t);

    start_layer(0, 0, 3, 2);
    wait_done(2000, -1, t);
    chk("zero_dim_latency", t, 2);

    start_layer(0, 1, 1, 2);
    wait_done(2000, 5, t);

    spur = 1;
    tick();
    tick();
    chk("err_sticky_set", err, 1);
    start_layer(3, 1, 2, 1);
    wait_done(2000, -1, t);
    chk("err_still_set", err, 1);

    start_layer(40, 3, 2, 2);
    repeat (8) tick();
    chk("busy_before_reset", busy, 1);
    mid_reset();
    start_layer(40, 3, 2, 2);
    wait_done(3000, -1, t);

    for (int i = 0; i < 8; i++) begin
      delay = $urandom_range(1, 6);
      start_layer($urandom_range(0, 255), $urandom_range(0, 4), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      wait_done(6000, $urandom_range(2, 20), t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
